// File: rtl/bnine_arb_pkg.sv
// Shared definitions for the instruction-ROM arbiter: FSM state type and
// port-owner identifiers used by the arbiter and its round-robin picker.
package bnine_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } arb_state_e;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_LOAD  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not
// own the previous transaction wins.
module rr_pick2
    import bnine_arb_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  logic       last_owner_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant_valid_o = |eligible_i;
        grant_idx_o   = OWNER_FETCH;
        if (&eligible_i) begin
            grant_idx_o = ~last_owner_i;
        end else if (eligible_i[1]) begin
            grant_idx_o = OWNER_LOAD;
        end
    end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares one instruction-ROM port between the fetch stage (port 0) and the
// loader/debug port (port 1): round-robin, one outstanding txn, flush, watchdog.
module inst_mem_arbiter
    import bnine_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              flush0_i,
    output logic              gnt0_o,
    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_data_o,
    output logic              rsp0_err_o,

    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic              flush1_i,
    output logic              gnt1_o,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_data_o,
    output logic              rsp1_err_o,

    output logic              mem_request_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_dataOk_i,

    output logic              spurious_o
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    arb_state_e          state_q;
    logic                owner_q;
    logic                last_owner_q;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_d;
    logic [1:0]          gnt_q;
    logic [1:0]          rsp_valid_q;
    logic [1:0]          rsp_err_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                mem_request_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                spurious_q;

    logic [1:0]          flush;
    logic [1:0]          eligible;
    logic                pick_valid;
    logic                pick_idx;
    logic                owner_flush;
    logic                timed_out;

    assign flush       = {flush1_i, flush0_i};
    assign eligible    = {req1_i, req0_i} & ~flush;
    assign owner_flush = flush[owner_q];
    // Saturating compare: a flush landing on the last cycle must still time out in DROP.
    assign timed_out   = (timer_q >= TIMER_LAST);
    assign timer_d     = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

    rr_pick2 u_pick (
        .eligible_i    (eligible),
        .last_owner_i  (last_owner_q),
        .grant_valid_o (pick_valid),
        .grant_idx_o   (pick_idx)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWNER_FETCH;
            last_owner_q  <= OWNER_LOAD;
            timer_q       <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= '0;
            rsp_data_q    <= '0;
            mem_request_q <= 1'b0;
            mem_addr_q    <= '0;
            spurious_q    <= 1'b0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (mem_dataOk_i) begin
                        spurious_q <= 1'b1;
                    end
                    if (pick_valid) begin
                        gnt_q[pick_idx] <= 1'b1;
                        owner_q         <= pick_idx;
                        mem_addr_q      <= pick_idx ? addr1_i : addr0_i;
                        mem_request_q   <= 1'b1;
                        timer_q         <= '0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    timer_q <= timer_d;
                    if (owner_flush) begin
                        state_q <= DROP;
                    end else if (mem_dataOk_i || timed_out) begin
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_err_q[owner_q]   <= ~mem_dataOk_i;
                        rsp_data_q           <= mem_dataOk_i ? mem_data_i : '0;
                        mem_request_q        <= 1'b0;
                        last_owner_q         <= owner_q;
                        state_q              <= IDLE;
                    end
                end
                DROP: begin
                    timer_q <= timer_d;
                    if (mem_dataOk_i || timed_out) begin
                        mem_request_q <= 1'b0;
                        last_owner_q  <= owner_q;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    mem_request_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign gnt0_o        = gnt_q[0];
    assign gnt1_o        = gnt_q[1];
    assign rsp0_valid_o  = rsp_valid_q[0];
    assign rsp1_valid_o  = rsp_valid_q[1];
    assign rsp0_err_o    = rsp_err_q[0];
    assign rsp1_err_o    = rsp_err_q[1];
    assign rsp0_data_o   = rsp_valid_q[0] ? rsp_data_q : '0;
    assign rsp1_data_o   = rsp_valid_q[1] ? rsp_data_q : '0;
    assign mem_request_o = mem_request_q;
    assign mem_addr_o    = mem_addr_q;
    assign spurious_o    = spurious_q;

    // Grants and responses are exclusive between the two ports.
    assert property (@(posedge clk) disable iff (reset) !(&gnt_q));
    assert property (@(posedge clk) disable iff (reset) !(&rsp_valid_q));

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Bench for inst_mem_arbiter: directed vector table, hand-written corner
// sequences, then random traffic checked against a transaction-level model.
module tb_inst_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, flush0, flush1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rv0, rv1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mdata;
    logic          mem_ok;
    logic          spurious;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    inst_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_i       (req0),
        .addr0_i      (addr0),
        .flush0_i     (flush0),
        .gnt0_o       (gnt0),
        .rsp0_valid_o (rv0),
        .rsp0_data_o  (rdata0),
        .rsp0_err_o   (err0),
        .req1_i       (req1),
        .addr1_i      (addr1),
        .flush1_i     (flush1),
        .gnt1_o       (gnt1),
        .rsp1_valid_o (rv1),
        .rsp1_data_o  (rdata1),
        .rsp1_err_o   (err1),
        .mem_request_o(mem_req),
        .mem_addr_o   (mem_addr),
        .mem_data_i   (mdata),
        .mem_dataOk_i (mem_ok),
        .spurious_o   (spurious)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mdata = rom_word(mem_addr);
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] f, input logic ok,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        {req1, req0}     = r;
        {flush1, flush0} = f;
        mem_ok           = ok;
        addr0            = a0;
        addr1            = a1;
    endtask

    typedef struct {
        logic [1:0]    gnt;
        logic [1:0]    rv;
        logic [1:0]    err;
        logic          mreq;
        logic [AW-1:0] ma;
        logic [DW-1:0] d;
        logic [1:0]    req;
        logic [1:0]    flush;
        logic          ok;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic [1:0] gnt, input logic [1:0] rv, input logic mreq,
                     input logic [AW-1:0] ma, input logic [DW-1:0] d,
                     input logic [1:0] r, input logic [1:0] f, input logic ok,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        vec_t e;
        e.gnt = gnt; e.rv = rv; e.err = 2'b00; e.mreq = mreq; e.ma = ma; e.d = d;
        e.req = r; e.flush = f; e.ok = ok; e.a0 = a0; e.a1 = a1;
        tbl.push_back(e);
    endtask

    // Transaction-level reference model state.
    logic          m_busy, m_owner, m_last, m_killed, m_spur;
    int            m_start;
    logic [AW-1:0] m_addr;
    logic [1:0]    e_gnt, e_rv, e_err;
    logic [DW-1:0] e_data;

    task automatic model_step();
        logic [1:0] elig;
        logic [1:0] fl;
        logic       pick;
        e_gnt  = 2'b00;
        e_rv   = 2'b00;
        e_err  = 2'b00;
        e_data = '0;
        fl     = {flush1, flush0};
        if (!m_busy) begin
            if (mem_ok) m_spur = 1'b1;
            elig = {req1, req0} & ~fl;
            if (elig != 2'b00) begin
                pick        = (elig == 2'b11) ? ~m_last : (elig == 2'b10);
                e_gnt[pick] = 1'b1;
                m_addr      = pick ? addr1 : addr0;
                m_busy      = 1'b1;
                m_owner     = pick;
                m_start     = cyc + 1;
                m_killed    = 1'b0;
            end
        end else begin
            if (!m_killed && fl[m_owner]) begin
                m_killed = 1'b1;
            end else if (mem_ok || (cyc - m_start >= TO - 1)) begin
                if (!m_killed) begin
                    e_rv[m_owner]  = 1'b1;
                    e_err[m_owner] = !mem_ok;
                    e_data         = mem_ok ? mdata : '0;
                end
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
    endtask

    initial begin
        int n;
        int due;
        logic prev_mreq;
        vec_t t;

        reset = 1'b1;
        drive(2'b00, 2'b00, 1'b0, '0, '0);
        mdata = '0;
        repeat (2) tick();
        check("rst gnt", {gnt1, gnt0}, 2'b00);
        check("rst rsp", {rv1, rv0, err1, err0}, 4'b0000);
        check("rst mreq", mem_req, 1'b0);
        check("rst maddr", mem_addr, 32'h0);
        check("rst spurious", spurious, 1'b0);
        reset = 1'b0;

        // Round-robin with both ports held, then ROM latency 2, flush cases.
        v(2'b00, 2'b00, 0, 32'h000, 0,              2'b11, 2'b00, 0, 32'h200, 32'h300);
        v(2'b01, 2'b00, 1, 32'h200, 0,              2'b11, 2'b00, 1, 32'h200, 32'h300);
        v(2'b00, 2'b01, 0, 32'h200, rom_word('h200), 2'b11, 2'b00, 0, 32'h200, 32'h300);
        v(2'b10, 2'b00, 1, 32'h300, 0,              2'b11, 2'b00, 1, 32'h200, 32'h300);
        v(2'b00, 2'b10, 0, 32'h300, rom_word('h300), 2'b11, 2'b00, 0, 32'h200, 32'h300);
        v(2'b01, 2'b00, 1, 32'h200, 0,              2'b11, 2'b00, 1, 32'h200, 32'h300);
        v(2'b00, 2'b01, 0, 32'h200, rom_word('h200), 2'b11, 2'b00, 0, 32'h200, 32'h300);
        v(2'b10, 2'b00, 1, 32'h300, 0,              2'b00, 2'b00, 1, 32'h200, 32'h300);
        v(2'b00, 2'b10, 0, 32'h300, rom_word('h300), 2'b01, 2'b00, 0, 32'h100, 32'h0);
        v(2'b01, 2'b00, 1, 32'h100, 0,              2'b00, 2'b00, 0, 32'h0,   32'h0);
        v(2'b00, 2'b00, 1, 32'h100, 0,              2'b00, 2'b00, 0, 32'h0,   32'h0);
        v(2'b00, 2'b00, 1, 32'h100, 0,              2'b00, 2'b00, 1, 32'h0,   32'h0);
        v(2'b00, 2'b01, 0, 32'h100, rom_word('h100), 2'b01, 2'b00, 0, 32'h400, 32'h0);
        v(2'b01, 2'b00, 1, 32'h400, 0,              2'b00, 2'b01, 0, 32'h0,   32'h0);
        v(2'b00, 2'b00, 1, 32'h400, 0,              2'b00, 2'b00, 0, 32'h0,   32'h0);
        v(2'b00, 2'b00, 1, 32'h400, 0,              2'b00, 2'b00, 1, 32'h0,   32'h0);
        v(2'b00, 2'b00, 0, 32'h400, 0,              2'b10, 2'b00, 0, 32'h0,   32'h500);
        v(2'b10, 2'b00, 1, 32'h500, 0,              2'b00, 2'b00, 1, 32'h0,   32'h0);
        v(2'b00, 2'b10, 0, 32'h500, rom_word('h500), 2'b01, 2'b00, 0, 32'h600, 32'h0);
        v(2'b01, 2'b00, 1, 32'h600, 0,              2'b00, 2'b01, 1, 32'h0,   32'h0);
        v(2'b00, 2'b00, 1, 32'h600, 0,              2'b00, 2'b00, 1, 32'h0,   32'h0);
        v(2'b00, 2'b00, 0, 32'h600, 0,              2'b11, 2'b10, 0, 32'h700, 32'h800);
        v(2'b01, 2'b00, 1, 32'h700, 0,              2'b00, 2'b10, 1, 32'h0,   32'h0);
        v(2'b00, 2'b01, 0, 32'h700, rom_word('h700), 2'b00, 2'b00, 0, 32'h0,   32'h0);
        v(2'b00, 2'b00, 0, 32'h700, 0,              2'b00, 2'b00, 0, 32'h0,   32'h0);

        for (int k = 0; k < tbl.size(); k++) begin
            t = tbl[k];
            check($sformatf("v%0d gnt", k), {gnt1, gnt0}, t.gnt);
            check($sformatf("v%0d rsp", k), {rv1, rv0}, t.rv);
            check($sformatf("v%0d err", k), {err1, err0}, t.err);
            check($sformatf("v%0d mreq", k), mem_req, t.mreq);
            check($sformatf("v%0d maddr", k), mem_addr, t.ma);
            check($sformatf("v%0d spurious", k), spurious, 1'b0);
            if (t.rv[0]) check($sformatf("v%0d data0", k), rdata0, t.d);
            if (t.rv[1]) check($sformatf("v%0d data1", k), rdata1, t.d);
            drive(t.req, t.flush, t.ok, t.a0, t.a1);
            tick();
        end

        // Silent ROM: error response 16 cycles after the grant, then a late dataOk.
        drive(2'b01, 2'b00, 1'b0, 32'h900, 32'h0);
        tick();
        check("to gnt0", gnt0, 1'b1);
        drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (n <= 40 && !rv0) begin
            tick();
            n++;
        end
        check("to latency", n, TO);
        check("to err0", err0, 1'b1);
        check("to data0", rdata0, 32'h0);
        check("to spurious pre", spurious, 1'b0);
        tick();
        mem_ok = 1'b1;
        tick();
        mem_ok = 1'b0;
        check("spur set", spurious, 1'b1);
        check("spur no rsp", {rv1, rv0}, 2'b00);
        repeat (3) tick();
        check("spur sticky", spurious, 1'b1);

        // Asynchronous reset in WAIT.
        drive(2'b01, 2'b00, 1'b0, 32'hA00, 32'h0);
        tick();
        drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        check("rw mreq before", mem_req, 1'b1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("rw mreq async", mem_req, 1'b0);
        check("rw maddr async", mem_addr, 32'h0);
        check("rw spurious async", spurious, 1'b0);
        tick();
        reset = 1'b0;
        mem_ok = 1'b1;
        tick();
        mem_ok = 1'b0;
        check("rw late data spurious", spurious, 1'b1);
        drive(2'b11, 2'b00, 1'b0, 32'hB00, 32'hC00);
        tick();
        check("rw first tie", {gnt1, gnt0}, 2'b01);
        check("rw first tie addr", mem_addr, 32'hB00);

        // Random traffic against the reference model.
        drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (2) tick();
        reset     = 1'b0;
        m_busy    = 1'b0;
        m_owner   = 1'b0;
        m_last    = 1'b1;
        m_killed  = 1'b0;
        m_spur    = 1'b0;
        m_start   = 0;
        m_addr    = '0;
        e_gnt     = 2'b00;
        e_rv      = 2'b00;
        e_err     = 2'b00;
        e_data    = '0;
        due       = -1;
        prev_mreq = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            check("rnd gnt", {gnt1, gnt0}, e_gnt);
            check("rnd rsp", {rv1, rv0}, e_rv);
            check("rnd err", {err1, err0}, e_err);
            if (e_rv[0]) check("rnd data0", rdata0, e_data);
            if (e_rv[1]) check("rnd data1", rdata1, e_data);
            check("rnd mreq", mem_req, m_busy);
            check("rnd maddr", mem_addr, m_addr);
            check("rnd spurious", spurious, m_spur);
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 3) != 0);
            flush0 = ($urandom_range(0, 15) == 0);
            flush1 = ($urandom_range(0, 15) == 0);
            addr0  = $urandom;
            addr1  = $urandom;
            if (mem_req && !prev_mreq) due = cyc + int'($urandom_range(0, 19));
            prev_mreq = mem_req;
            mem_ok    = (cyc == due);
            model_step();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
